// File: rtl/dmem_arbiter.sv
// Two-requester arbiter with a one-entry request stage in front of the single-port data memory.
// Requester 1 can lock the grant, bounded by MAX_LOCK. Define DMEM_ARB_MISALIGN_EN to add alignment errors.
module dmem_arbiter #(
   parameter int MAX_LOCK = 8,
   parameter int AW       = 32
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [2:0]    m0_size,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [2:0]    m1_size,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic          m1_lock,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic          mem_we,
   output logic [2:0]    mem_size,
   output logic [31:0]   mem_a,
   output logic [31:0]   mem_wd,
   input  logic [31:0]   mem_rd,
   output logic          stall_m0
`ifdef DMEM_ARB_MISALIGN_EN
   ,
   output logic          m0_err,
   output logic          m1_err
`endif
);

   // state | meaning
   // ARB   | round-robin between requesters, tie goes to !last_grant
   // LOCK  | requester 1 keeps the grant until it drops lock/req or lock_cnt reaches MAX_LOCK
   typedef enum logic {ARB, LOCK} state_t;

   localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

   state_t        r_state, w_state_nxt;
   logic          r_last_grant, w_last_grant_nxt;
   logic [7:0]    r_lock_cnt, w_lock_cnt_nxt;
   logic          w_gnt0, w_gnt1, w_any_gnt;

   logic          r_valid, r_id, r_we, r_err;
   logic [2:0]    r_size;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;

   logic          w_sel_we, w_sel_err, w_live;
   logic [2:0]    w_sel_size;
   logic [AW-1:0] w_sel_addr;
   logic [31:0]   w_sel_wdata;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= ARB;
         r_last_grant <= 1'b1;
         r_lock_cnt   <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_lock_cnt   <= w_lock_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_lock_cnt_nxt   = r_lock_cnt;
      w_last_grant_nxt = r_last_grant;
      if (w_gnt0)
         w_last_grant_nxt = 1'b0;
      else if (w_gnt1)
         w_last_grant_nxt = 1'b1;
      case (r_state)
         ARB: begin
            if (w_gnt1 && m1_lock) begin
               w_state_nxt    = LOCK;
               w_lock_cnt_nxt = m0_req ? 8'd1 : 8'd0;
            end
         end
         LOCK: begin
            // any cycle without a locked m1 grant (idle, unlock, or forced m0) ends the burst
            if (w_gnt1 && m1_lock) begin
               if (m0_req && (r_lock_cnt < LOCK_MAX))
                  w_lock_cnt_nxt = r_lock_cnt + 8'd1;
            end else begin
               w_state_nxt    = ARB;
               w_lock_cnt_nxt = 8'd0;
            end
         end
         default: begin
            w_state_nxt    = ARB;
            w_lock_cnt_nxt = 8'd0;
         end
      endcase
   end

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_state == LOCK) begin
         if (m1_req && !(m0_req && (r_lock_cnt >= LOCK_MAX)))
            w_gnt1 = 1'b1;
         else if (m0_req)
            w_gnt0 = 1'b1;
      end else if (m0_req && m1_req) begin
         w_gnt0 = r_last_grant;
         w_gnt1 = !r_last_grant;
      end else begin
         w_gnt0 = m0_req;
         w_gnt1 = m1_req;
      end
   end

   assign w_any_gnt   = w_gnt0 | w_gnt1;
   assign w_sel_we    = w_gnt1 ? m1_we    : (w_gnt0 & m0_we);
   assign w_sel_size  = w_gnt1 ? m1_size  : (w_gnt0 ? m0_size  : 3'd0);
   assign w_sel_addr  = w_gnt1 ? m1_addr  : (w_gnt0 ? m0_addr  : '0);
   assign w_sel_wdata = w_gnt1 ? m1_wdata : (w_gnt0 ? m0_wdata : 32'd0);

`ifdef DMEM_ARB_MISALIGN_EN
   assign w_sel_err = w_any_gnt &
                      ((((w_sel_size == 3'd1) || (w_sel_size == 3'd5)) && w_sel_addr[0]) ||
                       ((w_sel_size == 3'd2) && (w_sel_addr[1:0] != 2'b00)));
`else
   assign w_sel_err = 1'b0;
`endif

   // idle cycles load zeros so the memory-side outputs read 0 without extra gating
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_valid <= 1'b0;
         r_id    <= 1'b0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= 3'd0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
      end else begin
         r_valid <= w_any_gnt;
         r_id    <= w_gnt1;
         r_we    <= w_sel_we;
         r_err   <= w_sel_err;
         r_size  <= w_sel_size;
         r_addr  <= w_sel_addr;
         r_wdata <= w_sel_wdata;
      end
   end

   assign w_live    = r_valid & ~r_err;
   assign mem_we    = w_live & r_we;
   assign mem_size  = r_size;
   assign mem_a     = 32'(r_addr);
   assign mem_wd    = r_wdata;

   assign m0_rvalid = w_live & ~r_we & ~r_id;
   assign m1_rvalid = w_live & ~r_we & r_id;
   assign m0_rdata  = m0_rvalid ? mem_rd : 32'd0;
   assign m1_rdata  = m1_rvalid ? mem_rd : 32'd0;

   assign m0_gnt    = w_gnt0 & ~RESET;
   assign m1_gnt    = w_gnt1 & ~RESET;
   assign stall_m0  = m0_req & ~m0_gnt;

`ifdef DMEM_ARB_MISALIGN_EN
   assign m0_err    = r_valid & r_err & ~r_id;
   assign m1_err    = r_valid & r_err & r_id;
`endif

endmodule
